psum_requant: RTL and testbench

Output stage directly downstream of the PE. Consumes the PE's signed 32-bit `opsum`/`valid` stream and sums `ACC_LEN` consecutive valid partial sums into one output-channel value. It then requantizes the sum to int8 (multiply, rounding right shift, optional ReLU, saturation) and buffers the results in a small FIFO behind a valid/ready output port. The PE has no backpressure, so a full FIFO drops results and raises a sticky overflow flag.

---
 rtl/psum_requant_pkg.sv | 40 ++++
 rtl/psum_out_fifo.sv | 69 ++++++
 rtl/psum_requant.sv | 130 +++++++++++++
 tb/tb_psum_requant.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_requant_pkg.sv
// Shared widths, int8 limits and the requantization arithmetic for the PE output stage.
package psum_requant_pkg;

    localparam int unsigned ACC_W  = 40;
    localparam int unsigned PROD_W = 57;
    localparam int          INT8_MAX = 127;
    localparam int          INT8_MIN = -128;

    // Rounding arithmetic right shift (half up), optional ReLU, then clamp to int8.
    function automatic logic signed [7:0] requant(
        input logic signed [PROD_W-1:0] prod,
        input int unsigned              shift,
        input logic                     relu
    );
        logic signed [PROD_W-1:0] rnd;
        logic signed [PROD_W-1:0] r;
        logic signed [PROD_W-1:0] hi;
        logic signed [PROD_W-1:0] lo;
        hi = PROD_W'(INT8_MAX);
        lo = PROD_W'(INT8_MIN);
        if (shift == 0) begin
            rnd = prod;
            r   = prod;
        end else begin
            rnd = prod + (PROD_W'(1) << (shift - 1));
            r   = rnd >>> shift;
        end
        if (relu && r[PROD_W-1]) begin
            r = '0;
        end
        if (r > hi) begin
            requant = 8'(INT8_MAX);
        end else if (r < lo) begin
            requant = 8'(INT8_MIN);
        end else begin
            requant = r[7:0];
        end
    endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Small synchronous int8 FIFO with flush; a push into a full FIFO succeeds only alongside a pop.
module psum_out_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          nonempty;
    logic          do_push;
    logic          do_pop;

    assign empty = !nonempty;
    assign head  = mem[rd_ptr];

    always_comb begin
        do_pop   = pop && nonempty;
        do_push  = push && (!full || do_pop);
        count_nx = count;
        if (do_push && !do_pop) begin
            count_nx = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nx = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem      <= '{default: '0};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            nonempty <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            nonempty <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nx;
            full     <= (count_nx == CW'(DEPTH));
            nonempty <= (count_nx != '0);
        end
    end

endmodule

// File: rtl/psum_requant.sv
// PE output stage: accumulate ACC_LEN partial sums, requantize to int8, buffer in a lossy FIFO.
module psum_requant
    import psum_requant_pkg::*;
#(
    parameter int unsigned ACC_LEN    = 9,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MULT_W     = 16,
    parameter int unsigned SHIFT_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [31:0]        in_psum,
    input  logic                      clear,
    input  logic        [MULT_W-1:0]  cfg_mult,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    input  logic                      cfg_relu,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [7:0]         out_data,
    output logic                      ovf,
    output logic                      busy
);
    localparam int unsigned CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    logic        [CNT_W-1:0]   cnt;
    logic        [CNT_W-1:0]   cnt_nx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_nx;
    logic signed [ACC_W-1:0]   psum_ext;
    logic                      last;
    logic                      sum_done;
    logic                      s1_v;
    logic signed [ACC_W-1:0]   s1_sum;
    logic        [MULT_W-1:0]  s1_mult;
    logic        [SHIFT_W-1:0] s1_shift;
    logic                      s1_relu;
    logic                      s2_v;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  s2_prod;
    logic        [SHIFT_W-1:0] s2_shift;
    logic                      s2_relu;
    logic signed [7:0]         result;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      drop;
    logic                      busy_nx;

    assign psum_ext = ACC_W'(in_psum);
    assign last     = (cnt == CNT_W'(ACC_LEN - 1));
    assign sum_done = in_valid && last;

    always_comb begin
        cnt_nx = cnt;
        acc_nx = acc;
        if (in_valid) begin
            acc_nx = (cnt == '0) ? psum_ext : acc + psum_ext;
            cnt_nx = last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Multiplier is unsigned, so it is zero-extended before the signed multiply.
    assign prod    = PROD_W'(s1_sum) * PROD_W'($signed({1'b0, s1_mult}));
    assign result  = requant(s2_prod, 32'(s2_shift), s2_relu);
    assign busy_nx = (cnt_nx != '0) || sum_done || s1_v;

    // A full FIFO without a same-cycle pop cannot accept the result.
    assign drop      = s2_v && fifo_full && !out_ready;
    assign out_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            acc      <= '0;
            s1_v     <= 1'b0;
            s1_sum   <= '0;
            s1_mult  <= '0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
            s2_v     <= 1'b0;
            s2_prod  <= '0;
            s2_shift <= '0;
            s2_relu  <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            acc  <= '0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            ovf  <= 1'b0;
            busy <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            acc  <= acc_nx;
            s1_v <= sum_done;
            if (sum_done) begin
                s1_sum   <= acc_nx;
                s1_mult  <= cfg_mult;
                s1_shift <= cfg_shift;
                s1_relu  <= cfg_relu;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_prod  <= prod;
                s2_shift <= s1_shift;
                s2_relu  <= s1_relu;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            busy <= busy_nx;
        end
    end

    psum_out_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .push      (s2_v),
        .push_data (result),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant: transaction-level model plus hand-computed spot values.
module tb_psum_requant;

    localparam int ACC_LEN    = 9;
    localparam int FIFO_DEPTH = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] in_psum;
    logic               clear;
    logic        [15:0] cfg_mult;
    logic        [4:0]  cfg_shift;
    logic               cfg_relu;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               ovf;
    logic               busy;

    int compared   = 0;
    int mismatched = 0;

    psum_requant #(
        .ACC_LEN    (ACC_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MULT_W     (16),
        .SHIFT_W    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_psum   (in_psum),
        .clear     (clear),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_fifo[$];
    longint pend_val[$];
    int     pend_edge[$];
    int     m_cnt;
    longint m_sum;
    bit     m_ovf;
    int     edge_n;

    function automatic longint requant_m(input longint s, input longint m, input longint sh,
                                         input bit relu);
        longint p;
        longint d;
        longint q;
        p = s * m;
        if (sh == 0) begin
            q = p;
        end else begin
            d = longint'(1) << sh;
            p = p + d / 2;
            q = p / d;
            if ((p % d != 0) && (p < 0)) q = q - 1;
        end
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic m_reset();
        m_fifo.delete();
        pend_val.delete();
        pend_edge.delete();
        m_cnt = 0;
        m_sum = 0;
        m_ovf = 1'b0;
    endtask

    task automatic m_edge();
        bit popped;
        bit was_full;
        edge_n++;
        if (clear) begin
            m_reset();
        end else begin
            popped   = (m_fifo.size() > 0) && out_ready;
            was_full = (m_fifo.size() == FIFO_DEPTH);
            if (popped) void'(m_fifo.pop_front());
            while (pend_edge.size() > 0 && pend_edge[0] == edge_n) begin
                if (was_full && !popped) m_ovf = 1'b1;
                else m_fifo.push_back(pend_val[0]);
                void'(pend_val.pop_front());
                void'(pend_edge.pop_front());
            end
            if (in_valid) begin
                m_cnt++;
                m_sum += longint'(in_psum);
                if (m_cnt == ACC_LEN) begin
                    pend_val.push_back(requant_m(m_sum, longint'(cfg_mult),
                                                 longint'(cfg_shift), cfg_relu));
                    pend_edge.push_back(edge_n + 2);
                    m_cnt = 0;
                    m_sum = 0;
                end
            end
        end
    endtask

    initial begin
        edge_n = 0;
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_edge();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("out_valid", longint'(out_valid), longint'(m_fifo.size() > 0));
                if (m_fifo.size() > 0) chk("out_data", longint'($signed(out_data)), m_fifo[0]);
                chk("ovf", longint'(ovf), longint'(m_ovf));
                chk("busy", longint'(busy),
                    longint'((m_cnt != 0) || (pend_val.size() > 0)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_in(input bit v, input int p);
        @(negedge clk);
        in_valid = v;
        in_psum  = p;
    endtask

    task automatic feed(input int val, input int n);
        repeat (n) tick_in(1'b1, val);
    endtask

    task automatic idle(input int n);
        repeat (n) tick_in(1'b0, 0);
    endtask

    task automatic wait_out(input string nm, input int exp);
        int k;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            k++;
        end
        chk({nm, "_valid"}, longint'(out_valid), 1);
        chk(nm, longint'($signed(out_data)), exp);
    endtask

    int exp_pop[4] = '{9, 18, 27, 36};

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_psum   = 0;
        clear     = 1'b0;
        cfg_mult  = 16'd1;
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'($signed(out_data)), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_busy", longint'(busy), 0);
        rst = 1'b1;

        // Basic sum 1..9 = 45 with exact latency.
        for (int i = 1; i <= 9; i++) tick_in(1'b1, i);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_c1_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_c2_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_c3_valid", longint'(out_valid), 1);
        chk("lat_c3_data", longint'($signed(out_data)), 45);
        idle(2);

        // Rounding: 45*3/4 and -45*3/4.
        cfg_mult  = 16'd3;
        cfg_shift = 5'd2;
        for (int i = 1; i <= 9; i++) tick_in(1'b1, i);
        wait_out("rnd_pos", 34);
        for (int i = 1; i <= 9; i++) tick_in(1'b1, -i);
        wait_out("rnd_neg", -34);

        // Saturation and ReLU.
        cfg_mult  = 16'd1;
        cfg_shift = 5'd0;
        tick_in(1'b1, 1000);
        feed(0, 8);
        wait_out("sat_hi", 127);
        tick_in(1'b1, -1000);
        feed(0, 8);
        wait_out("sat_lo", -128);
        cfg_relu = 1'b1;
        tick_in(1'b1, -1000);
        feed(0, 8);
        wait_out("relu", 0);
        cfg_relu = 1'b0;
        idle(3);

        // Overflow: five results into a four-entry FIFO with no consumer.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) feed(k, 9);
        idle(4);
        chk("ovf_set", longint'(ovf), 1);
        chk("ovf_valid", longint'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop", longint'($signed(out_data)), exp_pop[i]);
            @(negedge clk);
        end
        chk("ovf_drained", longint'(out_valid), 0);
        chk("ovf_sticky", longint'(ovf), 1);

        // Clear mid-accumulation discards partial sum and the coincident psum.
        feed(7, 4);
        @(negedge clk);
        in_valid = 1'b1;
        in_psum  = 7;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_ovf", longint'(ovf), 0);
        chk("clr_busy", longint'(busy), 0);
        feed(2, 9);
        wait_out("clr_sum", 18);
        idle(3);
        chk("clr_ovf_after", longint'(ovf), 0);

        // Async reset with two entries held and a partial sum in flight.
        out_ready = 1'b0;
        feed(3, 9);
        feed(4, 9);
        idle(3);
        chk("pre_rst_valid", longint'(out_valid), 1);
        chk("pre_rst_head", longint'($signed(out_data)), 27);
        feed(5, 5);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_busy", longint'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", longint'(out_valid), 0);
        chk("arst_ovf", longint'(ovf), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_data", longint'($signed(out_data)), 0);
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) tick_in(1'b1, i);
        wait_out("post_rst", 45);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
